// File: rtl/core_pkg.sv
// Shared DCCM types: the request record passed through the port arbiter and
// the identity of the requester that owns an outstanding read.
package core_pkg;

  localparam int CORE_XLEN = 32;
  localparam int DCCM_AW   = 14;
  localparam int DCCM_BW   = CORE_XLEN / 8;

  typedef struct packed {
    logic                 we;
    logic [DCCM_AW-1:0]   addr;
    logic [CORE_XLEN-1:0] wdata;
    logic [DCCM_BW-1:0]   be;
  } dccm_req_t;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_DMA = 1'b1
  } dccm_owner_e;

endpackage

// File: rtl/dccm_arb_starve_cnt.sv
// Counts consecutive cycles a pending DMA request lost to the LSU and
// saturates at MAX_WAIT; at_max forces the next DMA grant.
module dccm_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dma_valid,
  input  logic lsu_grant,
  input  logic dma_grant,
  output logic at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_max = (cnt_q == CW'(MAX_WAIT));

  // Next-count: a DMA that wins or withdraws starts over with a clean slate
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_valid || dma_grant) begin
      cnt_d = {CW{1'b0}};
    end else if (lsu_grant && !at_max) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dccm_port_arbiter.sv
// Single-port DCCM arbiter between LSU (fixed priority) and DMA, with a
// starvation escape for DMA and a one-cycle read response steered to the owner.
module dccm_port_arbiter #(
  parameter int XLEN         = core_pkg::CORE_XLEN,
  parameter int DCCM_AW      = core_pkg::DCCM_AW,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 lsu_req_valid,
  output logic                 lsu_req_ready,
  input  logic                 lsu_req_we,
  input  logic [DCCM_AW-1:0]   lsu_req_addr,
  input  logic [XLEN-1:0]      lsu_req_wdata,
  input  logic [XLEN/8-1:0]    lsu_req_be,
  output logic                 lsu_rsp_valid,
  output logic [XLEN-1:0]      lsu_rsp_rdata,

  input  logic                 dma_req_valid,
  output logic                 dma_req_ready,
  input  logic                 dma_req_we,
  input  logic [DCCM_AW-1:0]   dma_req_addr,
  input  logic [XLEN-1:0]      dma_req_wdata,
  input  logic [XLEN/8-1:0]    dma_req_be,
  output logic                 dma_rsp_valid,
  output logic [XLEN-1:0]      dma_rsp_rdata,

  output logic                 dccm_en,
  output logic                 dccm_we,
  output logic [DCCM_AW-1:0]   dccm_addr,
  output logic [XLEN-1:0]      dccm_wdata,
  output logic [XLEN/8-1:0]    dccm_be,
  input  logic [XLEN-1:0]      dccm_rdata
);

  import core_pkg::*;

  dccm_req_t   lsu_req_s;
  dccm_req_t   dma_req_s;
  dccm_req_t   sel_req_s;
  logic        lsu_win_s;
  logic        dma_win_s;
  logic        at_max_s;
  logic        pending_q;
  logic        pending_d;
  dccm_owner_e owner_q;
  dccm_owner_e owner_d;

  assign lsu_req_s = '{we: lsu_req_we, addr: lsu_req_addr, wdata: lsu_req_wdata, be: lsu_req_be};
  assign dma_req_s = '{we: dma_req_we, addr: dma_req_addr, wdata: dma_req_wdata, be: dma_req_be};

  dccm_arb_starve_cnt #(
    .MAX_WAIT (DMA_MAX_WAIT)
  ) u_starve_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .dma_valid (dma_req_valid),
    .lsu_grant (lsu_win_s),
    .dma_grant (dma_win_s),
    .at_max    (at_max_s)
  );

  // Grant decision; nothing is granted while reset is held
  always_comb begin
    lsu_win_s = 1'b0;
    dma_win_s = 1'b0;
    if (!rst_n) begin
      lsu_win_s = 1'b0;
      dma_win_s = 1'b0;
    end else if (dma_req_valid && (!lsu_req_valid || at_max_s)) begin
      dma_win_s = 1'b1;
    end else if (lsu_req_valid) begin
      lsu_win_s = 1'b1;
    end else begin
      lsu_win_s = 1'b0;
      dma_win_s = 1'b0;
    end
  end

  // Winner mux and response bookkeeping for the next cycle
  always_comb begin
    sel_req_s = '0;
    owner_d   = owner_q;
    pending_d = 1'b0;
    if (dma_win_s) begin
      sel_req_s = dma_req_s;
      owner_d   = OWN_DMA;
    end else if (lsu_win_s) begin
      sel_req_s = lsu_req_s;
      owner_d   = OWN_LSU;
    end else begin
      sel_req_s = '0;
      owner_d   = owner_q;
    end
    pending_d = (lsu_win_s | dma_win_s) & ~sel_req_s.we;
  end

  // Outstanding-read owner and pending flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      owner_q   <= OWN_LSU;
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
    end
  end

  assign lsu_req_ready = lsu_win_s;
  assign dma_req_ready = dma_win_s;

  assign dccm_en    = lsu_win_s | dma_win_s;
  assign dccm_we    = sel_req_s.we;
  assign dccm_addr  = sel_req_s.addr;
  assign dccm_wdata = sel_req_s.wdata;
  assign dccm_be    = sel_req_s.be;

  // Gating by rst_n drops a response that was in flight when reset arrived
  assign lsu_rsp_valid = rst_n & pending_q & (owner_q == OWN_LSU);
  assign dma_rsp_valid = rst_n & pending_q & (owner_q == OWN_DMA);
  assign lsu_rsp_rdata = lsu_rsp_valid ? dccm_rdata : {XLEN{1'b0}};
  assign dma_rsp_rdata = dma_rsp_valid ? dccm_rdata : {XLEN{1'b0}};

endmodule

// File: tb/tb_dccm_port_arbiter.sv
// Directed bench: stimulus pushes expected request-side and response values into
// queues, a negedge monitor pops and compares against the DUT.
module tb_dccm_port_arbiter;

  localparam int WIN_NONE = 0;
  localparam int WIN_LSU  = 1;
  localparam int WIN_DMA  = 2;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [13:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
  } rq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req_valid = 1'b0, lsu_req_we = 1'b0;
  logic [13:0] lsu_req_addr = 14'h0;
  logic [31:0] lsu_req_wdata = 32'h0;
  logic [3:0]  lsu_req_be = 4'h0;
  logic        dma_req_valid = 1'b0, dma_req_we = 1'b0;
  logic [13:0] dma_req_addr = 14'h0;
  logic [31:0] dma_req_wdata = 32'h0;
  logic [3:0]  dma_req_be = 4'h0;
  logic        lsu_req_ready, dma_req_ready, lsu_rsp_valid, dma_rsp_valid;
  logic [31:0] lsu_rsp_rdata, dma_rsp_rdata;
  logic        dccm_en, dccm_we;
  logic [13:0] dccm_addr;
  logic [31:0] dccm_wdata;
  logic [3:0]  dccm_be;
  logic [31:0] dccm_rdata = 32'h0;

  logic [31:0] mem [0:16383];
  logic [53:0] exp_req_q [$];
  logic [31:0] exp_lsu_q [$];
  logic [31:0] exp_dma_q [$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dccm_port_arbiter #(.XLEN(32), .DCCM_AW(14), .DMA_MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_be(lsu_req_be),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata), .dma_req_be(dma_req_be),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
    .dccm_en(dccm_en), .dccm_we(dccm_we), .dccm_addr(dccm_addr), .dccm_wdata(dccm_wdata),
    .dccm_be(dccm_be), .dccm_rdata(dccm_rdata)
  );

  // SRAM model: one-cycle registered read, byte-enabled write
  always @(posedge clk) begin
    if (dccm_en) begin
      if (dccm_we) begin
        for (int b = 0; b < 4; b++) begin
          if (dccm_be[b]) mem[dccm_addr][b*8 +: 8] <= dccm_wdata[b*8 +: 8];
        end
      end else begin
        dccm_rdata <= mem[dccm_addr];
      end
    end
  end

  function automatic rq_t ld(input logic [13:0] a);
    return '{v: 1'b1, we: 1'b0, a: a, wd: 32'h0, be: 4'h0};
  endfunction

  function automatic rq_t st(input logic [13:0] a, input logic [31:0] wd, input logic [3:0] be);
    return '{v: 1'b1, we: 1'b1, a: a, wd: wd, be: be};
  endfunction

  function automatic rq_t nrq();
    return '{v: 1'b0, we: 1'b0, a: 14'h0, wd: 32'h0, be: 4'h0};
  endfunction

  // One clock of stimulus; win is the hand-determined winner, rdat the expected load data
  task automatic cyc(input logic rst, input rq_t l, input rq_t d, input int win,
                     input logic [31:0] rdat, input bit keep_rsp);
    rq_t sel;
    logic [53:0] e;
    @(posedge clk);
    #1;
    rst_n = rst;
    lsu_req_valid = l.v; lsu_req_we = l.we; lsu_req_addr = l.a;
    lsu_req_wdata = l.wd; lsu_req_be = l.be;
    dma_req_valid = d.v; dma_req_we = d.we; dma_req_addr = d.a;
    dma_req_wdata = d.wd; dma_req_be = d.be;
    sel = (win == WIN_DMA) ? d : l;
    if (win == WIN_NONE) begin
      e = 54'h0;
    end else begin
      e = {(win == WIN_LSU), (win == WIN_DMA), 1'b1, sel.we, sel.a, sel.wd, sel.be};
      if (!sel.we && keep_rsp) begin
        if (win == WIN_LSU) exp_lsu_q.push_back(rdat);
        else exp_dma_q.push_back(rdat);
      end
    end
    exp_req_q.push_back(e);
  endtask

  // Monitor: compare request side every cycle, responses whenever presented
  always @(negedge clk) begin
    logic [53:0] got, exp_r;
    logic [31:0] ex;
    if (exp_req_q.size() != 0) begin
      exp_r = exp_req_q.pop_front();
      got = {lsu_req_ready, dma_req_ready, dccm_en, dccm_we, dccm_addr, dccm_wdata, dccm_be};
      checks++;
      if (got !== exp_r) begin
        failures++;
        $display("FAIL req_side t=%0t got=%h exp=%h", $time, got, exp_r);
      end
    end
    checks++;
    if (lsu_rsp_valid) begin
      if (exp_lsu_q.size() == 0) begin
        failures++;
        $display("FAIL lsu_rsp_unexpected t=%0t got=%h exp=none", $time, lsu_rsp_rdata);
      end else begin
        ex = exp_lsu_q.pop_front();
        if (lsu_rsp_rdata !== ex) begin
          failures++;
          $display("FAIL lsu_rsp_data t=%0t got=%h exp=%h", $time, lsu_rsp_rdata, ex);
        end
      end
    end else if (lsu_rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL lsu_rdata_idle t=%0t got=%h exp=0", $time, lsu_rsp_rdata);
    end
    checks++;
    if (dma_rsp_valid) begin
      if (exp_dma_q.size() == 0) begin
        failures++;
        $display("FAIL dma_rsp_unexpected t=%0t got=%h exp=none", $time, dma_rsp_rdata);
      end else begin
        ex = exp_dma_q.pop_front();
        if (dma_rsp_rdata !== ex) begin
          failures++;
          $display("FAIL dma_rsp_data t=%0t got=%h exp=%h", $time, dma_rsp_rdata, ex);
        end
      end
    end else if (dma_rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL dma_rdata_idle t=%0t got=%h exp=0", $time, dma_rsp_rdata);
    end
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE0000 | i;
    mem[14'h010] = 32'hDEADBEEF;

    // Reset with idle inputs, then idle operation
    cyc(1'b0, nrq(), nrq(), WIN_NONE, 32'h0, 1'b0);
    cyc(1'b0, nrq(), nrq(), WIN_NONE, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, nrq(), nrq(), WIN_NONE, 32'h0, 1'b0);

    // Single LSU load
    cyc(1'b1, ld(14'h010), nrq(), WIN_LSU, 32'hDEADBEEF, 1'b1);
    cyc(1'b1, nrq(), nrq(), WIN_NONE, 32'h0, 1'b0);

    // Starvation: LSU wins four cycles, DMA the fifth, LSU again after the count clears
    cyc(1'b1, ld(14'h020), ld(14'h030), WIN_LSU, 32'hC0DE0020, 1'b1);
    cyc(1'b1, ld(14'h021), ld(14'h030), WIN_LSU, 32'hC0DE0021, 1'b1);
    cyc(1'b1, ld(14'h022), ld(14'h030), WIN_LSU, 32'hC0DE0022, 1'b1);
    cyc(1'b1, ld(14'h023), ld(14'h030), WIN_LSU, 32'hC0DE0023, 1'b1);
    cyc(1'b1, ld(14'h024), ld(14'h030), WIN_DMA, 32'hC0DE0030, 1'b1);
    cyc(1'b1, ld(14'h024), ld(14'h031), WIN_LSU, 32'hC0DE0024, 1'b1);
    cyc(1'b1, nrq(), nrq(), WIN_NONE, 32'h0, 1'b0);

    // DMA partial store at the top address, then read it back on the LSU
    cyc(1'b1, nrq(), st(14'h3FFF, 32'h12345678, 4'b0011), WIN_DMA, 32'h0, 1'b0);
    cyc(1'b1, nrq(), nrq(), WIN_NONE, 32'h0, 1'b0);
    cyc(1'b1, ld(14'h3FFF), nrq(), WIN_LSU, 32'hC0DE5678, 1'b1);

    // Back-to-back LSU loads
    cyc(1'b1, ld(14'h001), nrq(), WIN_LSU, 32'hC0DE0001, 1'b1);
    cyc(1'b1, ld(14'h002), nrq(), WIN_LSU, 32'hC0DE0002, 1'b1);
    cyc(1'b1, ld(14'h003), nrq(), WIN_LSU, 32'hC0DE0003, 1'b1);
    cyc(1'b1, nrq(), nrq(), WIN_NONE, 32'h0, 1'b0);

    // Wait count clears when DMA withdraws, so LSU gets four fresh wins afterwards
    cyc(1'b1, st(14'h100, 32'hAAAA0000, 4'hF), ld(14'h010), WIN_LSU, 32'h0, 1'b0);
    cyc(1'b1, st(14'h101, 32'hAAAA0001, 4'hF), ld(14'h010), WIN_LSU, 32'h0, 1'b0);
    cyc(1'b1, st(14'h102, 32'hAAAA0002, 4'hF), nrq(), WIN_LSU, 32'h0, 1'b0);
    cyc(1'b1, st(14'h103, 32'hAAAA0003, 4'hF), ld(14'h010), WIN_LSU, 32'h0, 1'b0);
    cyc(1'b1, st(14'h104, 32'hAAAA0004, 4'hF), ld(14'h010), WIN_LSU, 32'h0, 1'b0);
    cyc(1'b1, st(14'h105, 32'hAAAA0005, 4'hF), ld(14'h010), WIN_LSU, 32'h0, 1'b0);
    cyc(1'b1, st(14'h106, 32'hAAAA0006, 4'hF), ld(14'h010), WIN_LSU, 32'h0, 1'b0);
    cyc(1'b1, st(14'h107, 32'hAAAA0007, 4'hF), ld(14'h010), WIN_DMA, 32'hDEADBEEF, 1'b1);
    cyc(1'b1, ld(14'h105), nrq(), WIN_LSU, 32'hAAAA0005, 1'b1);

    // Reset right after a granted load: its response must never appear
    cyc(1'b1, ld(14'h002), nrq(), WIN_LSU, 32'h0, 1'b0);
    cyc(1'b0, ld(14'h005), ld(14'h006), WIN_NONE, 32'h0, 1'b0);
    cyc(1'b0, nrq(), nrq(), WIN_NONE, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, nrq(), nrq(), WIN_NONE, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_req_q.size() != 0 || exp_lsu_q.size() != 0 || exp_dma_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained req=%0d lsu=%0d dma=%0d exp=0", exp_req_q.size(),
               exp_lsu_q.size(), exp_dma_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
